// File: rtl/audio_pkg.sv
// Shared types and helpers for the flash sample player.
package audio_pkg;

  // Native sample width of the audio path; the flash word carries two samples.
  localparam int SAMPLE_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LO,
    PLAY_LO,
    WAIT_HI,
    PLAY_HI,
    DONE
  } player_state_t;

  // Attenuate a signed sample by an arithmetic right shift (sign kept, truncating).
  // Operates on int so any sample width up to 32 bits can use it after sign extension.
  function automatic int shift_sample(input int s, input int sh);
    return s >>> sh;
  endfunction

endpackage

// File: rtl/flash_sample_player_if.sv
// Flash read data in, audio samples and status out.
interface flash_sample_player_if #(
  parameter int SAMPLE_W   = 16,
  parameter int UNDERRUN_W = 8
);
  logic [2*SAMPLE_W-1:0] flash_mem_readdata;
  logic                  flash_mem_readdatavalid;
  logic                  sample_tick;
  logic                  enable;
  logic [SAMPLE_W-1:0]   audio_data;
  logic                  audio_valid;
  logic                  word_done;
  logic                  busy;
  logic [UNDERRUN_W-1:0] underrun_count;
  logic                  overrun;

  // Producer side: flash read stage, tick source and control.
  modport master (
    output flash_mem_readdata, flash_mem_readdatavalid, sample_tick, enable,
    input  audio_data, audio_valid, word_done, busy, underrun_count, overrun
  );

  // Player side.
  modport slave (
    input  flash_mem_readdata, flash_mem_readdatavalid, sample_tick, enable,
    output audio_data, audio_valid, word_done, busy, underrun_count, overrun
  );
endinterface

// File: rtl/flash_sample_player_sat_counter.sv
// Saturating up-counter with asynchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increments, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/flash_sample_player.sv
// Plays each 32-bit flash word as two signed samples (low half first), one per sample_tick.
module flash_sample_player
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
  parameter int GAIN_SHIFT = 0,
  parameter int UNDERRUN_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  flash_sample_player_if.slave bus
);

  player_state_t         state_reg;
  logic [2*SAMPLE_W-1:0] word_reg;
  logic [SAMPLE_W-1:0]   audio_reg;
  logic                  valid_reg;
  logic                  done_reg;
  logic                  busy_reg;
  logic                  overrun_reg;
  logic [SAMPLE_W-1:0]   lo_scaled;
  logic [SAMPLE_W-1:0]   hi_scaled;
  logic                  underrun_inc;

  // Attenuated halves of the buffered word; sign-extended before the shift.
  assign lo_scaled = SAMPLE_W'(shift_sample(int'($signed(word_reg[SAMPLE_W-1:0])), GAIN_SHIFT));
  assign hi_scaled = SAMPLE_W'(shift_sample(int'($signed(word_reg[2*SAMPLE_W-1:SAMPLE_W])), GAIN_SHIFT));

  // A tick with no word in hand (idle, or finishing the previous word) is a starved tick.
  assign underrun_inc = bus.enable && bus.sample_tick && ((state_reg == IDLE) || (state_reg == DONE));

  sat_counter #(.W(UNDERRUN_W)) u_underrun (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (underrun_inc),
    .count (bus.underrun_count)
  );

  // Playback FSM with registered sample, strobes, busy and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      audio_reg   <= '0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (!bus.enable) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        if (bus.flash_mem_readdatavalid && (state_reg != IDLE)) begin
          overrun_reg <= 1'b1;
        end
        case (state_reg)
          IDLE: begin
            if (bus.flash_mem_readdatavalid) begin
              word_reg  <= bus.flash_mem_readdata;
              state_reg <= WAIT_LO;
              busy_reg  <= 1'b1;
            end
          end
          WAIT_LO: begin
            if (bus.sample_tick) state_reg <= PLAY_LO;
          end
          PLAY_LO: begin
            audio_reg <= lo_scaled;
            valid_reg <= 1'b1;
            state_reg <= WAIT_HI;
          end
          WAIT_HI: begin
            if (bus.sample_tick) state_reg <= PLAY_HI;
          end
          PLAY_HI: begin
            audio_reg <= hi_scaled;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end
          DONE: begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.audio_data  = audio_reg;
  assign bus.audio_valid = valid_reg;
  assign bus.word_done   = done_reg;
  assign bus.busy        = busy_reg;
  assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_flash_sample_player.sv
// Testbench: two players (gain shift 0 and 2) on shared stimulus, checked every cycle
// against a behavioural model, plus table-driven words and hand-written corner cases.
module tb_flash_sample_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] drv_rd = '0;
  logic        drv_rdv = 1'b0;
  logic        drv_tick = 1'b0;
  logic        drv_en = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_sample_player_if #(.SAMPLE_W(16), .UNDERRUN_W(8)) bus0 ();
  flash_sample_player_if #(.SAMPLE_W(16), .UNDERRUN_W(8)) bus2 ();

  assign bus0.flash_mem_readdata      = drv_rd;
  assign bus0.flash_mem_readdatavalid = drv_rdv;
  assign bus0.sample_tick             = drv_tick;
  assign bus0.enable                  = drv_en;
  assign bus2.flash_mem_readdata      = drv_rd;
  assign bus2.flash_mem_readdatavalid = drv_rdv;
  assign bus2.sample_tick             = drv_tick;
  assign bus2.enable                  = drv_en;

  flash_sample_player #(.SAMPLE_W(16), .GAIN_SHIFT(0), .UNDERRUN_W(8)) u_g0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
  );
  flash_sample_player #(.SAMPLE_W(16), .GAIN_SHIFT(2), .UNDERRUN_W(8)) u_g2 (
    .clk (clk), .rst_n (rst_n), .bus (bus2)
  );

  // ---------------- behavioural reference model ----------------
  // Tracks "holding a word", which half is next, and whether a sample or the
  // completion pulse is due on the coming clock.
  logic        m_have_word;
  logic [31:0] m_word;
  logic        m_next_hi;
  logic        m_sample_due;
  logic        m_finish_due;
  logic [15:0] m_audio [2];
  logic        m_av;
  logic        m_wd;
  int          m_uc;
  logic        m_ovr;
  logic        chk_en = 1'b0;

  function automatic logic [15:0] scaled(input logic [15:0] half, input int g);
    int  s;
    real q;
    s = int'($signed(half));
    q = $floor(real'(s) / (2.0 ** g));
    return 16'(int'(q));
  endfunction

  task automatic model_reset();
    m_have_word = 1'b0; m_word = '0; m_next_hi = 1'b0; m_sample_due = 1'b0;
    m_finish_due = 1'b0; m_audio[0] = '0; m_audio[1] = '0; m_av = 1'b0;
    m_wd = 1'b0; m_uc = 0; m_ovr = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic t, input logic e, input logic [31:0] d);
    logic [15:0] half;
    m_av = 1'b0;
    m_wd = 1'b0;
    if (!e) begin
      m_have_word = 1'b0; m_sample_due = 1'b0; m_finish_due = 1'b0;
    end else if (!m_have_word) begin
      if (t && m_uc < 255) m_uc++;
      if (v) begin m_have_word = 1'b1; m_word = d; m_next_hi = 1'b0; end
    end else begin
      if (v) m_ovr = 1'b1;
      if (m_sample_due) begin
        half = m_next_hi ? m_word[31:16] : m_word[15:0];
        m_audio[0] = scaled(half, 0);
        m_audio[1] = scaled(half, 2);
        m_av = 1'b1;
        m_sample_due = 1'b0;
        if (m_next_hi) m_finish_due = 1'b1;
        else m_next_hi = 1'b1;
      end else if (m_finish_due) begin
        m_wd = 1'b1; m_have_word = 1'b0; m_finish_due = 1'b0;
        if (t && m_uc < 255) m_uc++;
      end else if (t) begin
        m_sample_due = 1'b1;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic compare_model();
    check("g0_audio_data", 32'(bus0.audio_data), 32'(m_audio[0]));
    check("g2_audio_data", 32'(bus2.audio_data), 32'(m_audio[1]));
    check("audio_valid",   32'({bus0.audio_valid, bus2.audio_valid}), 32'({m_av, m_av}));
    check("word_done",     32'({bus0.word_done, bus2.word_done}), 32'({m_wd, m_wd}));
    check("busy",          32'({bus0.busy, bus2.busy}), 32'({m_have_word, m_have_word}));
    check("underrun_count", 32'(bus0.underrun_count), 32'(m_uc));
    check("overrun",       32'({bus0.overrun, bus2.overrun}), 32'({m_ovr, m_ovr}));
  endtask

  task automatic step();
    logic v, t, e;
    logic [31:0] d;
    v = drv_rdv; t = drv_tick; e = drv_en; d = drv_rd;
    @(posedge clk);
    model_update(v, t, e, d);
    #1;
    if (chk_en) compare_model();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    drv_rd = w; drv_rdv = 1'b1;
    step();
    drv_rdv = 1'b0; drv_rd = '0;
  endtask

  // Wait gap cycles, tick, then look (bounded) for the resulting audio_valid.
  task automatic tick_capture(input int gap, output logic [15:0] a0, output logic [15:0] a2, output int lat);
    repeat (gap) step();
    drv_tick = 1'b1;
    step();
    drv_tick = 1'b0;
    lat = -1; a0 = '0; a2 = '0;
    for (int i = 0; i < 4 && lat < 0; i++) begin
      step();
      if (bus0.audio_valid) begin lat = i; a0 = bus0.audio_data; a2 = bus2.audio_data; end
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          gap;
    logic [15:0] lo0, hi0, lo2, hi2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a0, a2;
    int lat, uc_before, since_tick;

    vecs[0] = '{32'h8000_1234, 1136, 16'h1234, 16'h8000, 16'h048D, 16'hE000};
    vecs[1] = '{32'hFFF0_0040, 3,    16'h0040, 16'hFFF0, 16'h0010, 16'hFFFC};
    vecs[2] = '{32'h7FFF_FFFF, 7,    16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h1FFF};
    vecs[3] = '{32'h0002_0001, 2,    16'h0001, 16'h0002, 16'h0000, 16'h0000};

    // Reset values.
    apply_reset();
    chk_en = 1'b1;
    check("reset_audio_data", 32'(bus0.audio_data), 32'h0);
    check("reset_flags", 32'({bus0.audio_valid, bus0.word_done, bus0.busy, bus0.overrun}), 32'h0);
    check("reset_underrun", 32'(bus0.underrun_count), 32'h0);

    // Three starved ticks after reset.
    repeat (3) begin drv_tick = 1'b1; step(); drv_tick = 1'b0; step(); end
    check("starved3_underrun", 32'(bus0.underrun_count), 32'd3);
    check("starved3_audio", 32'(bus0.audio_data), 32'h0);
    apply_reset();

    // Table-driven words.
    for (int k = 0; k < 4; k++) begin
      send_word(vecs[k].word);
      tick_capture(vecs[k].gap, a0, a2, lat);
      $display("word %h lo: g0=%h g2=%h lat=%0d", vecs[k].word, a0, a2, lat);
      check("tbl_lo_latency", 32'(lat), 32'd0);
      check("tbl_lo_g0", 32'(a0), 32'(vecs[k].lo0));
      check("tbl_lo_g2", 32'(a2), 32'(vecs[k].lo2));
      tick_capture(vecs[k].gap, a0, a2, lat);
      $display("word %h hi: g0=%h g2=%h lat=%0d", vecs[k].word, a0, a2, lat);
      check("tbl_hi_latency", 32'(lat), 32'd0);
      check("tbl_hi_g0", 32'(a0), 32'(vecs[k].hi0));
      check("tbl_hi_g2", 32'(a2), 32'(vecs[k].hi2));
      step();
      check("tbl_word_done", 32'({bus0.word_done, bus2.word_done}), 32'b11);
      step();
      check("tbl_word_done_single", 32'(bus0.word_done), 32'b0);
    end

    // Overrun: new word arrives during WAIT_HI and must be dropped.
    send_word(32'h0002_0001);
    tick_capture(3, a0, a2, lat);
    check("ovr_lo", 32'(a0), 32'h0001);
    send_word(32'hDEAD_BEEF);
    check("ovr_flag", 32'(bus0.overrun), 32'h1);
    tick_capture(3, a0, a2, lat);
    $display("overrun case hi: g0=%h overrun=%b", a0, bus0.overrun);
    check("ovr_hi", 32'(a0), 32'h0002);
    step();
    check("ovr_word_done", 32'(bus0.word_done), 32'h1);
    step();

    // Same-cycle readdatavalid and tick while idle.
    uc_before = m_uc;
    drv_rd = 32'h1111_2222; drv_rdv = 1'b1; drv_tick = 1'b1;
    step();
    drv_rdv = 1'b0; drv_tick = 1'b0; drv_rd = '0;
    check("same_cycle_underrun", 32'(bus0.underrun_count), 32'(uc_before + 1));
    check("same_cycle_busy", 32'(bus0.busy), 32'h1);
    tick_capture(2, a0, a2, lat);
    $display("same-cycle case lo: g0=%h lat=%0d", a0, lat);
    check("same_cycle_lo", 32'(a0), 32'h2222);
    tick_capture(2, a0, a2, lat);
    check("same_cycle_hi", 32'(a0), 32'h1111);
    repeat (2) step();

    // Asynchronous reset during WAIT_HI.
    send_word(32'h0004_0003);
    tick_capture(2, a0, a2, lat);
    check("rst_case_lo", 32'(a0), 32'h0003);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-word: audio=%h busy=%b uc=%0d", bus0.audio_data, bus0.busy, bus0.underrun_count);
    check("async_rst_audio", 32'(bus0.audio_data), 32'h0);
    check("async_rst_flags", 32'({bus0.audio_valid, bus0.word_done, bus0.busy, bus0.overrun}), 32'h0);
    check("async_rst_underrun", 32'(bus0.underrun_count), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv_tick = 1'b1; step(); drv_tick = 1'b0; step();
    send_word(32'h0006_0005);
    tick_capture(4, a0, a2, lat);
    check("post_rst_lo", 32'(a0), 32'h0005);
    tick_capture(4, a0, a2, lat);
    check("post_rst_hi", 32'(a0), 32'h0006);
    step();
    check("post_rst_word_done", 32'(bus0.word_done), 32'h1);

    // Randomized traffic with enable toggling, checked every cycle by the model.
    since_tick = 10;
    for (int c = 0; c < 3000; c++) begin
      drv_rdv  = ($urandom_range(0, 15) == 0);
      drv_rd   = $urandom();
      drv_tick = (since_tick >= 2) && ($urandom_range(0, 3) == 0);
      if (drv_en) begin
        if ($urandom_range(0, 99) == 0) drv_en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        drv_en = 1'b1;
      end
      since_tick = drv_tick ? 1 : since_tick + 1;
      step();
    end
    drv_rdv = 1'b0; drv_tick = 1'b0; drv_en = 1'b1;
    step();
    $display("random phase done: underrun=%0d overrun=%b", bus0.underrun_count, bus0.overrun);

    // Saturation: 300 starved ticks leave the counter at all-ones.
    repeat (300) begin drv_tick = 1'b1; step(); drv_tick = 1'b0; step(); end
    $display("saturation: underrun=%0d", bus0.underrun_count);
    check("underrun_saturate", 32'(bus0.underrun_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
